// File: rtl/mem_wr_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_wr_port_arbiter: round-robin arbiter granting up to two writers per cycle
// onto the two write ports of a dual-write register memory. Rev 1.0
// ============================================================================
module mem_wr_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 4,
  parameter int DW   = 4,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              stall,
  output logic              we1,
  output logic [AW-1:0]     wa1,
  output logic [DW-1:0]     wd1,
  output logic              we2,
  output logic [AW-1:0]     wa2,
  output logic [DW-1:0]     wd2,
  output logic [CW-1:0]     conflict_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          we1_q, we1_d, we2_q, we2_d;
  logic [AW-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
  logic [DW-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          en;
  logic          g1_vld, g2_vld, clash;
  logic [PW-1:0] g1_idx, g2_idx, last_idx;
  logic [AW-1:0] g1_addr;
  int            sel_idx;

  // Walk requesters from ptr; anything matching G1's address is deferred so the
  // two ports never target the same word in one cycle.
  always_comb begin
    en      = rst_n && !stall;
    g1_vld  = 1'b0;
    g2_vld  = 1'b0;
    clash   = 1'b0;
    g1_idx  = '0;
    g2_idx  = '0;
    g1_addr = '0;
    sel_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      sel_idx = int'(ptr_q) + k;
      if (sel_idx >= NREQ) sel_idx = sel_idx - NREQ;
      if (en && req_valid[sel_idx]) begin
        if (!g1_vld) begin
          g1_vld  = 1'b1;
          g1_idx  = PW'(sel_idx);
          g1_addr = req_addr[sel_idx*AW +: AW];
        end else if (req_addr[sel_idx*AW +: AW] == g1_addr) begin
          clash = 1'b1;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = PW'(sel_idx);
        end
      end
    end
    req_ready = '0;
    if (g1_vld) req_ready[g1_idx] = 1'b1;
    if (g2_vld) req_ready[g2_idx] = 1'b1;
  end

  always_comb begin
    we1_d    = g1_vld;
    we2_d    = g2_vld;
    wa1_d    = wa1_q;
    wd1_d    = wd1_q;
    wa2_d    = wa2_q;
    wd2_d    = wd2_q;
    if (g1_vld) begin
      wa1_d = req_addr[g1_idx*AW +: AW];
      wd1_d = req_data[g1_idx*DW +: DW];
    end
    if (g2_vld) begin
      wa2_d = req_addr[g2_idx*AW +: AW];
      wd2_d = req_data[g2_idx*DW +: DW];
    end
    last_idx = g2_vld ? g2_idx : g1_idx;
    ptr_d    = ptr_q;
    if (g1_vld) ptr_d = (last_idx == PW'(NREQ-1)) ? '0 : last_idx + 1'b1;
    cnt_d = (clash && (cnt_q != {CW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      we1_q <= 1'b0;
      we2_q <= 1'b0;
      wa1_q <= '0;
      wd1_q <= '0;
      wa2_q <= '0;
      wd2_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we1_q <= we1_d;
      we2_q <= we2_d;
      wa1_q <= wa1_d;
      wd1_q <= wd1_d;
      wa2_q <= wa2_d;
      wd2_q <= wd2_d;
      cnt_q <= cnt_d;
    end
  end

  assign we1          = we1_q;
  assign wa1          = wa1_q;
  assign wd1          = wd1_q;
  assign we2          = we2_q;
  assign wa2          = wa2_q;
  assign wd2          = wd2_q;
  assign conflict_cnt = cnt_q;

  a_port_addr_distinct: assert property (@(posedge clk) disable iff (!rst_n)
    (we1_q && we2_q) |-> (wa1_q != wa2_q));

endmodule
`default_nettype wire
